// File: rtl/shift_frame_sequencer.sv
// shift_frame_sequencer: command-driven frame engine around a bidirectional
// shift register. A parallel word is loaded on a command handshake, shifted out
// serially on sout while sin is captured, and the captured register is returned
// on a response handshake.
//
// Handshake rule (both channels): a transfer happens on the rising clk edge
// where valid and ready are both high; valid, once raised by the producer, is
// held with stable payload until that edge, and ready may be raised or dropped
// freely.
module shift_frame_sequencer #(
  parameter int size = 16,
  localparam int LW = $clog2(size + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [size-1:0] cmd_data,
  input  logic            cmd_dir,
  input  logic [LW-1:0]   cmd_len,
  input  logic            abort,
  input  logic            sin,
  output logic            sout,
  output logic            busy,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [size-1:0] rsp_data,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [LW-1:0] FULL_LEN = LW'(size);

  state_t          state_q, state_d;
  logic [size-1:0] sr_q, sr_d;
  logic [LW-1:0]   cnt_q, cnt_d;
  logic            dir_q, dir_d;

  logic            cmd_accept;
  logic [LW-1:0]   eff_len;

  // Zero or oversized lengths fall back to a full-width frame.
  assign eff_len = ((cmd_len == '0) || (cmd_len > FULL_LEN)) ? FULL_LEN : cmd_len;

  // Only IDLE takes commands; abort and reset both hold the door shut.
  assign cmd_ready  = rst && (state_q == IDLE) && !abort;
  assign cmd_accept = cmd_valid && cmd_ready;

  // Outputs decoded directly from registered state.
  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == DONE);
  assign rsp_data  = (state_q == DONE) ? sr_q : '0;
  assign sout      = (state_q == SHIFT) ? (dir_q ? sr_q[0] : sr_q[size-1]) : 1'b0;
  assign dbg_state = state_q;

  // Next-state logic for the frame FSM and its datapath registers.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    case (state_q)
      IDLE: begin
        if (cmd_accept) begin
          sr_d    = cmd_data;
          dir_d   = cmd_dir;
          cnt_d   = eff_len;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          sr_d    = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          if (dir_q) begin
            sr_d = {sin, sr_q[size-1:1]};
          end else begin
            sr_d = {sr_q[size-2:0], sin};
          end
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == LW'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (abort) begin
          sr_d    = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

endmodule
